tap_delay_line: RTL and testbench
=================================

// Module: tap_delay_line
// PURPOSE
//   Parametrised successor to the fixed-depth shift register. WIDTH-bit data plus a
//   per-stage valid bit shift through DEPTH stages on each enabled clock. A runtime
//   tap select picks the output stage, giving a programmable 1..DEPTH-cycle delay.
//   Adds synchronous flush, an occupancy counter and a flat all-taps bus.
//   Used wherever pipelines need a run-time-tunable delay for aligning data.
// PARAMETERS
//   WIDTH  4  data width per stage, >=1
//   DEPTH  8  number of stages, >=2
//   SEL_W  localparam = clog2(DEPTH); width of sel
//   CNT_W  localparam = clog2(DEPTH+1); width of fill_cnt
// PORTS
//   clk       in   1            clock, all state on posedge
//   rst_n     in   1            asynchronous active-low reset
//   en        in   1            shift enable
//   clr       in   1            synchronous flush, has priority over en
//   d         in   WIDTH        data into stage 0
//   d_valid   in   1            valid qualifier for d
//   sel       in   SEL_W        tap select, 0 = stage 0
//   q         out  WIDTH        data at the selected tap (combinational mux of regs)
//   q_valid   out  1            valid bit at the selected tap
//   taps      out  DEPTH*WIDTH  all stages flat; stage i at [i*WIDTH +: WIDTH]
//   fill_cnt  out  CNT_W        number of stages holding valid=1
// BEHAVIOUR
//   - Reset (rst_n=0, async assert, sync release): all stages, valid bits and
//     fill_cnt are 0. q=0, q_valid=0 and taps=0 while in reset.
//   - Per posedge, priority clr > en > hold:
//     clr: all data<=0, valid<=0, fill_cnt<=0 (d is discarded even if en=1).
//     en:  stage[0]<=d, v[0]<=d_valid; stage[i]<=stage[i-1], v[i]<=v[i-1].
//          Stage DEPTH-1 content is dropped.
//     else: all state holds.
//   - q = stage[sel_c] and q_valid = v[sel_c], where sel_c = min(sel, DEPTH-1).
//     Out-of-range sel clamps to DEPTH-1. Changing sel affects q in the same cycle.
//   - Latency: d appears on q after sel_c+1 enabled clocks. Disabled cycles do not
//     count toward the latency.
//   - fill_cnt on en (no clr): next = fill_cnt + d_valid - v[DEPTH-1].
//     It never exceeds DEPTH or goes below 0.
//   - fill_cnt invariant: it always equals popcount(v). An assertion checks this.
//   - X on d is only stored if en=1. Control inputs must be known out of reset.
// STRUCTURE
//   - Shared include tap_delay_line_defs.vh holds the clog2 constant function and
//     the default WIDTH/DEPTH macros, so benches and instantiators use the same values.
//   - One sub-module, delay_stage: a WIDTH+1-bit register with async reset, clr and en.
//     It is instantiated DEPTH times in a generate loop.
//   - The tap mux and fill counter live in the top level.
// TESTING
//   1 reset: assert rst_n=0 mid-run with 5 valid entries -> q=0, q_valid=0,
//     fill_cnt=0 immediately; after release, state stays 0 until en.
//   2 delay: DEPTH=8, sel=3, en=1, stream d=1..10 valid -> q=1 on the 4th edge,
//     then q=2,3,... one per cycle; fill_cnt saturates at 8.
//   3 stall: sel=7, push d=1..3, drop en for 4 cycles, then resume -> q stays put
//     while en=0; q=1 after the 8th enabled edge in total.
//   4 flush: fill to 8, assert clr with en=1 and d=9 -> next cycle all taps 0,
//     q_valid=0, fill_cnt=0; value 9 is not captured.
//   5 tap switch and clamp: full line holding 1..8, step sel 0..7 in one held cycle
//     -> q=8,7,...,1; with DEPTH=6 and sel=7, q equals stage[5].
//   6 bubbles: alternate d_valid 1/0 for 16 cycles -> q_valid toggles at the tap;
//     fill_cnt stays at 4 once steady with DEPTH=8.

Source files
------------

// File: rtl/tap_delay_line_pkg.sv
// Package for the tap delay line: default sizes, width helper and the
// per-cycle operation decode shared by the top level.
package tap_delay_line_pkg;

`include "tap_delay_line_defs.vh"

   localparam int TDL_WIDTH = `TDL_DEFAULT_WIDTH;
   localparam int TDL_DEPTH = `TDL_DEFAULT_DEPTH;

   // What the whole line does on the next clock edge.
   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_SHIFT = 2'd1,
      OP_CLR   = 2'd2
   } tdl_op_e;

endpackage

// File: rtl/tap_delay_line_defs.vh
// Shared definitions for the tap delay line: default geometry and the
// ceil(log2) helper used to size select and count ports.
`ifndef TAP_DELAY_LINE_DEFS_VH
`define TAP_DELAY_LINE_DEFS_VH

`define TDL_DEFAULT_WIDTH 4
`define TDL_DEFAULT_DEPTH 8

// Smallest r such that 2**r >= value (returns 0 for value <= 1).
function automatic int tdl_clog2(input int value);
   int result;
   int remain;
   result = 0;
   remain = value - 1;
   while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
   end
   return result;
endfunction

`endif

// File: rtl/tap_delay_line_delay_stage.sv
// One stage of the delay line: a data word plus its valid bit, stored in a
// single register with asynchronous reset, synchronous clear and enable.
module delay_stage #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] data_reg;

   // Stage register: clear wins over enable, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg <= '0;
      end else if (clr) begin
         data_reg <= '0;
      end else if (en) begin
         data_reg <= d;
      end
   end

   assign q = data_reg;

endmodule

// File: rtl/tap_delay_line.sv
// Programmable-depth delay line: DEPTH stages of data+valid shift on each
// enabled clock, a runtime tap select picks the output stage (clamped to the
// last stage), and a counter tracks how many stages hold valid data.
module tap_delay_line
   import tap_delay_line_pkg::*;
#(
   parameter  int WIDTH = TDL_WIDTH,
   parameter  int DEPTH = TDL_DEPTH,
   localparam int SEL_W = tdl_clog2(DEPTH),
   localparam int CNT_W = tdl_clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   clr,
   input  logic [WIDTH-1:0]       d,
   input  logic                   d_valid,
   input  logic [SEL_W-1:0]       sel,
   output logic [WIDTH-1:0]       q,
   output logic                   q_valid,
   output logic [DEPTH*WIDTH-1:0] taps,
   output logic [CNT_W-1:0]       fill_cnt
);

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DEPTH - 1);

   // Each stage word is {valid, data}.
   logic [WIDTH:0]   stage_q [DEPTH];
   logic [DEPTH-1:0] valid;
   tdl_op_e          op;
   logic [SEL_W-1:0] sel_c;
   logic [CNT_W-1:0] fill_cnt_reg;
   logic [CNT_W-1:0] fill_cnt_next;

   assign op = clr ? OP_CLR : (en ? OP_SHIFT : OP_HOLD);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [WIDTH:0] stage_d;

         if (gi == 0) begin : g_head
            assign stage_d = {d_valid, d};
         end else begin : g_body
            assign stage_d = stage_q[gi-1];
         end

         delay_stage #(
            .W (WIDTH + 1)
         ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .en    (en),
            .d     (stage_d),
            .q     (stage_q[gi])
         );

         assign valid[gi]                   = stage_q[gi][WIDTH];
         assign taps[gi*WIDTH +: WIDTH]     = stage_q[gi][WIDTH-1:0];
      end
   endgenerate

   // Tap mux: out-of-range selects read the last stage.
   always_comb begin
      sel_c   = (sel > LAST_SEL) ? LAST_SEL : sel;
      q       = stage_q[sel_c][WIDTH-1:0];
      q_valid = stage_q[sel_c][WIDTH];
   end

   // Occupancy update: a valid word enters at stage 0, one may fall off the end.
   always_comb begin
      fill_cnt_next = fill_cnt_reg;
      case (op)
         OP_CLR:   fill_cnt_next = '0;
         OP_SHIFT: fill_cnt_next = fill_cnt_reg + CNT_W'(d_valid)
                                   - CNT_W'(valid[DEPTH-1]);
         default:  fill_cnt_next = fill_cnt_reg;
      endcase
   end

   // Occupancy register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_cnt_reg <= '0;
      end else begin
         fill_cnt_reg <= fill_cnt_next;
      end
   end

   assign fill_cnt = fill_cnt_reg;

   // The counter is a cached popcount of the valid bits; they must never diverge.
   fill_matches_valid: assert property (
      @(posedge clk) disable iff (!rst_n)
      fill_cnt_reg == CNT_W'($countones(valid))
   );

endmodule

// File: tb/tb_tap_delay_line.sv
// Directed bench for tap_delay_line: an 8-deep and a 6-deep instance share
// stimulus; expected values are hand-derived per scenario.
module tb_tap_delay_line;
   import tap_delay_line_pkg::*;

   localparam int W      = 4;
   localparam int D8     = 8;
   localparam int D6     = 6;
   localparam int SEL_W  = tdl_clog2(D8);
   localparam int CNT8_W = tdl_clog2(D8 + 1);
   localparam int CNT6_W = tdl_clog2(D6 + 1);

   logic               clk;
   logic               rst_n;
   logic               en;
   logic               clr;
   logic [W-1:0]       d;
   logic               d_valid;
   logic [SEL_W-1:0]   sel;

   logic [W-1:0]       q8;
   logic               q_valid8;
   logic [D8*W-1:0]    taps8;
   logic [CNT8_W-1:0]  fill8;

   logic [W-1:0]       q6;
   logic               q_valid6;
   logic [D6*W-1:0]    taps6;
   logic [CNT6_W-1:0]  fill6;

   int n_checks;
   int n_fail;

   tap_delay_line #(.WIDTH(W), .DEPTH(D8)) dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (clr),
      .d        (d),
      .d_valid  (d_valid),
      .sel      (sel),
      .q        (q8),
      .q_valid  (q_valid8),
      .taps     (taps8),
      .fill_cnt (fill8)
   );

   tap_delay_line #(.WIDTH(W), .DEPTH(D6)) dut6 (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (clr),
      .d        (d),
      .d_valid  (d_valid),
      .sel      (sel),
      .q        (q6),
      .q_valid  (q_valid6),
      .taps     (taps6),
      .fill_cnt (fill6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Advance one clock and land 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      clr      = 1'b0;
      d        = '0;
      d_valid  = 1'b0;
      sel      = '0;

      // ---- 1: reset ----
      #12;
      check("rst_q", 32'(q8), 0);
      check("rst_qv", 32'(q_valid8), 0);
      check("rst_fill", 32'(fill8), 0);
      rst_n = 1'b1;
      step();
      step();
      check("post_rst_taps", taps8, 0);
      check("post_rst_fill", 32'(fill8), 0);
      en = 1'b1;
      d_valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         d = W'(k);
         step();
      end
      en = 1'b0;
      check("pre_rst_fill", 32'(fill8), 5);
      check("pre_rst_q", 32'(q8), 5);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_q", 32'(q8), 0);
      check("async_rst_qv", 32'(q_valid8), 0);
      check("async_rst_fill", 32'(fill8), 0);
      check("async_rst_taps", taps8, 0);
      step();
      rst_n = 1'b1;
      step();
      step();
      check("idle_after_rst_taps", taps8, 0);
      check("idle_after_rst_fill", 32'(fill8), 0);

      // ---- 2: delay of 4 with sel=3 ----
      sel = 3'd3;
      en = 1'b1;
      d_valid = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         d = W'(k);
         step();
         if (k >= 4) begin
            check($sformatf("delay_q_e%0d", k), 32'(q8), 32'(k - 3));
            check($sformatf("delay_qv_e%0d", k), 32'(q_valid8), 1);
         end else begin
            check($sformatf("delay_qv_e%0d", k), 32'(q_valid8), 0);
         end
         check($sformatf("delay_fill_e%0d", k), 32'(fill8), 32'((k < 8) ? k : 8));
      end

      // ---- 3: stall ----
      en = 1'b0;
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("stall_clr_fill", 32'(fill8), 0);
      sel = 3'd7;
      en = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         d = W'(k);
         step();
      end
      en = 1'b0;
      d = 4'hF;
      for (int c = 0; c < 4; c++) begin
         step();
         check($sformatf("stall_qv_c%0d", c), 32'(q_valid8), 0);
         check($sformatf("stall_tap2_c%0d", c), 32'(taps8[2*W +: W]), 1);
         check($sformatf("stall_fill_c%0d", c), 32'(fill8), 3);
      end
      en = 1'b1;
      for (int k = 4; k <= 8; k++) begin
         d = W'(k);
         step();
         if (k < 8) begin
            check($sformatf("resume_qv_e%0d", k), 32'(q_valid8), 0);
         end
      end
      check("resume_q", 32'(q8), 1);
      check("resume_qv", 32'(q_valid8), 1);

      // ---- 4: flush over a full line ----
      check("full_fill", 32'(fill8), 8);
      clr = 1'b1;
      en = 1'b1;
      d = 4'd9;
      step();
      clr = 1'b0;
      en = 1'b0;
      check("flush_taps", taps8, 0);
      check("flush_qv", 32'(q_valid8), 0);
      check("flush_fill", 32'(fill8), 0);
      check("flush_taps6", 32'(taps6), 0);

      // ---- 5: tap switch and clamp ----
      en = 1'b1;
      d_valid = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         d = W'(k);
         step();
      end
      en = 1'b0;
      for (int s = 0; s < 8; s++) begin
         sel = SEL_W'(s);
         #1;
         check($sformatf("tapsel_q_s%0d", s), 32'(q8), 32'(8 - s));
      end
      sel = 3'd7;
      #1;
      check("clamp6_q", 32'(q6), 3);
      check("clamp6_qv", 32'(q_valid6), 1);
      check("clamp6_fill", 32'(fill6), 6);
      sel = 3'd2;
      #1;
      check("sel6_q_s2", 32'(q6), 6);

      // ---- 6: bubbles ----
      clr = 1'b1;
      step();
      clr = 1'b0;
      sel = 3'd3;
      en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         d = W'(k);
         d_valid = k[0];
         step();
         if (k >= 4) begin
            check($sformatf("bubble_qv_e%0d", k), 32'(q_valid8), 32'((k - 3) % 2));
         end
         check($sformatf("bubble_fill_e%0d", k), 32'(fill8), 32'((k < 8) ? (k + 1) / 2 : 4));
      end
      en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
